// File: rtl/arb4_way16.sv
// -----------------------------------------------------------------------------
// arb4_way16 -- four-requester round-robin arbiter feeding a one-entry,
// full-throughput output buffer.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : asynchronous, active-high reset
//   in_a..in_d : 16-bit data words from requesters 0..3
//   req        : per-requester request, req[i] pairs with word i
//   grant      : one-hot, combinational; grant[i]=1 means word i is taken now
//   out        : registered output word
//   sel        : registered index of the requester whose word is in out
//   out_valid  : out/sel hold a word not yet accepted downstream
//   out_ready  : downstream accepts out when out_valid && out_ready at an edge
// -----------------------------------------------------------------------------
module arb4_way16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_c,
  input  logic [15:0] in_d,
  input  logic [3:0]  req,
  output logic [3:0]  grant,
  output logic [15:0] out,
  output logic [1:0]  sel,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] out_q, out_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  last_q, last_d;

  logic        can_accept;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  probe;
  logic [15:0] win_word;
  logic        take;

  // A draining buffer can be refilled on the same edge, so the slot is
  // available whenever it is empty or its current word is leaving.
  assign can_accept = (state_q == EMPTY) || out_ready;

  // Round-robin search: probe last+1, last+2, last+3 and finally last itself;
  // the 2-bit addition provides the 3->0 wrap for free.
  // NOTE: every variable written in a combinational block gets a default
  // assignment at the top so no path leaves it unassigned (no latch).
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    probe     = last_q;
    for (int k = 1; k <= 4; k++) begin
      probe = last_q + 2'(k);
      if (!win_found && req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  // Grant is forced low during reset so nothing is taken while state is
  // being cleared.
  assign take  = !reset && can_accept && win_found;
  assign grant = take ? (4'b0001 << win_idx) : 4'b0000;

  always_comb begin
    case (win_idx)
      2'd0:    win_word = in_a;
      2'd1:    win_word = in_b;
      2'd2:    win_word = in_c;
      default: win_word = in_d;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (take) begin
      // Covers both EMPTY fill and FULL drain-and-refill.
      state_d = FULL;
      out_d   = win_word;
      sel_d   = win_idx;
      last_d  = win_idx;
    end else if (state_q == FULL && out_ready) begin
      // Word leaves with nothing behind it; out/sel keep their last values.
      state_d = EMPTY;
    end
  end

  // last resets to 3 so requester 0 has first priority after reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      out_q   <= 16'h0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign out       = out_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_arb4_way16.sv
// -----------------------------------------------------------------------------
// tb_arb4_way16 -- directed scenarios followed by a randomized run. The
// stimulus process predicts each grant from a round-robin reference model and
// pushes the expected word/index into a scoreboard queue; a separate monitor
// pops and compares whenever the DUT delivers a word.
// -----------------------------------------------------------------------------
module tb_arb4_way16;

  logic        clk;
  logic        reset;
  logic [15:0] in_a, in_b, in_c, in_d;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [15:0] out;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;

  arb4_way16 dut (
    .clk       (clk),
    .reset     (reset),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .req       (req),
    .grant     (grant),
    .out       (out),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] word;
    logic [1:0]  idx;
  } sb_t;

  sb_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state shared with the monitor.
  bit mon_en  = 1'b0;
  bit m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+3 with reset released.
  task automatic do_reset();
    req       = 4'b0000;
    out_ready = 1'b0;
    reset     = 1'b1;
    #2;
    reset     = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a word is delivered at the coming edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", out_valid, m_valid);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("out_word", out, e.word);
          check("out_sel", sel, e.idx);
        end
      end
    end
  end

  initial begin
    logic [15:0] dw [5];
    logic [1:0]  di [5];
    logic [3:0]  dg [5];
    logic [3:0]  rq;
    logic [15:0] words [4];
    int          waitc [4];
    int          m_last, nl, win;
    bit          nv, can;
    logic [3:0]  exp_g;

    reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
    in_a = 16'h0; in_b = 16'h0; in_c = 16'h0; in_d = 16'h0;

    // Reset state, and grant stays low during reset even with requests.
    #2;
    req = 4'b1111;
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_out", out, 16'h0000);
    check("rst_sel", sel, 2'd0);
    check("rst_valid", out_valid, 1'b0);

    // Single word: first grant opportunity is the first edge after release.
    @(posedge clk); #1;
    reset = 1'b0; req = 4'b0001; in_a = 16'h1234; out_ready = 1'b1;
    #1 check("single_grant", grant, 4'b0001);
    next_cycle();
    check("single_out", out, 16'h1234);
    check("single_sel", sel, 2'd0);
    check("single_valid", out_valid, 1'b1);
    req = 4'b0000;
    #1 check("idle_grant", grant, 4'b0000);
    next_cycle();
    check("drain_valid", out_valid, 1'b0);
    check("drain_hold_out", out, 16'h1234);

    // All requesting: rotation 0,1,2,3,0 at full throughput.
    do_reset();
    in_a = 16'h000A; in_b = 16'h000B; in_c = 16'h000C; in_d = 16'h000D;
    req = 4'b1111; out_ready = 1'b1;
    dg[0] = 4'b0001; dg[1] = 4'b0010; dg[2] = 4'b0100; dg[3] = 4'b1000; dg[4] = 4'b0001;
    dw[0] = 16'hA; dw[1] = 16'hB; dw[2] = 16'hC; dw[3] = 16'hD; dw[4] = 16'hA;
    di[0] = 2'd0; di[1] = 2'd1; di[2] = 2'd2; di[3] = 2'd3; di[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      #1 check("rr_grant", grant, dg[i]);
      next_cycle();
      check("rr_out", out, dw[i]);
      check("rr_sel", sel, di[i]);
      check("rr_valid", out_valid, 1'b1);
    end

    // Stall while holding 0x00FF from requester 2.
    req = 4'b0100; in_c = 16'h00FF;
    #1 check("stall_fill_grant", grant, 4'b0100);
    next_cycle();
    out_ready = 1'b0; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_grant", grant, 4'b0000);
      check("stall_out", out, 16'h00FF);
      check("stall_sel", sel, 2'd2);
      check("stall_valid", out_valid, 1'b1);
      next_cycle();
    end
    out_ready = 1'b1;
    #1 check("post_stall_grant", grant, 4'b1000);
    next_cycle();
    check("post_stall_out", out, 16'h000D);
    check("post_stall_sel", sel, 2'd3);

    // Reset while FULL discards the buffered word.
    req = 4'b0001; in_a = 16'hBEEF;
    #1 check("beef_grant", grant, 4'b0001);
    next_cycle();
    check("beef_out", out, 16'hBEEF);
    out_ready = 1'b0; req = 4'b1010;
    reset = 1'b1;
    #1;
    check("midrst_out", out, 16'h0000);
    check("midrst_sel", sel, 2'd0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_grant", grant, 4'b0000);
    #1 reset = 1'b0;
    #1 check("after_rst_grant", grant, 4'b0010);
    next_cycle();
    check("after_rst_out", out, 16'h000B);
    check("after_rst_sel", sel, 2'd1);

    // Randomized run against the reference model.
    next_cycle();
    do_reset();
    rq = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      words[i] = 16'h0;
      waitc[i] = 0;
    end
    m_valid = 1'b0; m_last = 3; nv = 1'b0; nl = 3;
    mon_en = 1'b1;

    for (int cyc = 0; cyc < 10040; cyc++) begin
      @(posedge clk);
      m_valid = nv;
      m_last  = nl;
      #1;
      // New requests only in the main window; held requests stay until granted.
      for (int i = 0; i < 4; i++) begin
        if (!rq[i] && cyc < 10000) begin
          rq[i]    = ($urandom_range(0, 99) < 40);
          words[i] = 16'($urandom);
        end
      end
      out_ready = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 99) < 60);
      req  = rq;
      in_a = words[0]; in_b = words[1]; in_c = words[2]; in_d = words[3];
      #1;
      can   = !m_valid || out_ready;
      win   = -1;
      exp_g = 4'b0000;
      if (can && rq != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (m_last + k) % 4;
          if (win < 0 && rq[j]) win = j;
        end
        for (int i = 0; i < 4; i++)
          if (rq[i]) waitc[i]++;
        exp_g[win] = 1'b1;
      end
      check("rand_grant", grant, exp_g);
      if (win >= 0) begin
        sb_t e;
        check("starvation", (waitc[win] <= 4), 1'b1);
        waitc[win] = 0;
        e.word = words[win];
        e.idx  = 2'(win);
        sb.push_back(e);
        rq[win] = 1'b0;
        nv = 1'b1;
        nl = win;
      end else begin
        nv = out_ready ? 1'b0 : m_valid;
        nl = m_last;
      end
    end

    // The drain window leaves nothing granted but undelivered.
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
